controller_request_sender: RTL and testbench

- Initiator for the request/confirm/inputData handshake consumed by the P/Q register controller.
- Accepts (target, 7-bit payload) words from an upstream producer and buffers them in a small FIFO.
- Drains the FIFO one transaction at a time, sequencing request, data setup and confirm so the controller loads the payload into register P or Q.

---
 rtl/controller_request_sender.sv | 92 +++++++++
 tb/tb_controller_request_sender.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/controller_request_sender.sv
// controller_request_sender: FIFO-buffered request/setup/confirm initiator for the P/Q register controller.
// Define CTRL_REQUEST_SENDER_DROP_COUNT_EN to add the saturating drop_count output.
module controller_request_sender #(
  parameter int DEPTH = 4,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  input  logic push_target,
  input  logic [6:0] push_data,
  output logic push_ready,
  output logic request,
  output logic confirm,
  output logic [7:0] inputData,
  output logic busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef CTRL_REQUEST_SENDER_DROP_COUNT_EN
  , output logic [7:0] drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int MAXC = SETUP_CYC > GAP_CYC ? SETUP_CYC : GAP_CYC;
  localparam int CW = MAXC > 2 ? $clog2(MAXC) : 1;
  typedef enum logic [2:0] {IDLE, REQ, SETUP, CONF, GAP} stateT;
  stateT state, nextState;
  logic [CW-1:0] cnt, nextCnt;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [7:0] nextData;
  logic pushFire, pop;
  // push_ready depends only on the registered count, never on this cycle's pop
  assign push_ready = fifo_count != (AW+1)'(DEPTH);
  assign pushFire = push_valid & push_ready;
  assign pop = state == IDLE && fifo_count != '0;
  assign busy = state != IDLE;
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    nextData = inputData;
    case (state)
      IDLE: if (pop) begin
        nextState = REQ;
        nextData = mem[rdPtr];
      end
      REQ: begin
        nextState = SETUP;
        nextCnt = CW'(SETUP_CYC - 1);
      end
      SETUP: if (cnt == '0) nextState = CONF; else nextCnt = cnt - 1'b1;
      CONF: begin
        nextState = (GAP_CYC == 0) ? IDLE : GAP;
        nextCnt = CW'(GAP_CYC - 1);
        nextData = '0;
      end
      GAP: if (cnt == '0) nextState = IDLE; else nextCnt = cnt - 1'b1;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (pushFire) mem[wrPtr] <= {push_data, push_target};
  end
  // request/confirm/inputData are registered from the next-state decode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      request <= 1'b0;
      confirm <= 1'b0;
      inputData <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      fifo_count <= '0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      request <= nextState == REQ;
      confirm <= nextState == CONF;
      inputData <= nextData;
      wrPtr <= wrPtr + AW'(pushFire);
      rdPtr <= rdPtr + AW'(pop);
      fifo_count <= fifo_count + (AW+1)'(pushFire) - (AW+1)'(pop);
    end
  end
`ifdef CTRL_REQUEST_SENDER_DROP_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) drop_count <= '0;
    else if (push_valid && !push_ready && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_controller_request_sender.sv
// tb_controller_request_sender: directed vector table plus multi-cycle sequences for controller_request_sender.
module tb_controller_request_sender;
  logic clock = 1'b0, reset = 1'b0;
  logic pv, pt, pv2, pt2;
  logic [6:0] pd, pd2;
  logic rdy, req, conf, bsy, rdy2, req2, conf2, bsy2;
  logic [7:0] dat, dat2;
  logic [2:0] cnt, cnt2;
`ifdef CTRL_REQUEST_SENDER_DROP_COUNT_EN
  logic [7:0] drop, drop2;
`endif
  int vectors = 0, miscompares = 0, cyc = 0, overlap = 0;
  bit sawFull = 1'b0;
  logic [7:0] reqQ[$], confQ[$], r2D[$];
  int r2T[$], c2T[$];
  typedef struct {
    logic pv; logic pt; logic [6:0] pd;
    logic rq; logic cf; logic [7:0] dat; logic bs; logic rdy; logic [2:0] cnt;
  } vecT;
  vecT tbl [16];
  logic [7:0] exp6 [6];

  controller_request_sender dut (
    .clock(clock), .reset(reset), .push_valid(pv), .push_target(pt), .push_data(pd),
    .push_ready(rdy), .request(req), .confirm(conf), .inputData(dat), .busy(bsy),
    .fifo_count(cnt)
`ifdef CTRL_REQUEST_SENDER_DROP_COUNT_EN
    , .drop_count(drop)
`endif
  );
  controller_request_sender #(.DEPTH(4), .SETUP_CYC(1), .GAP_CYC(0)) dut2 (
    .clock(clock), .reset(reset), .push_valid(pv2), .push_target(pt2), .push_data(pd2),
    .push_ready(rdy2), .request(req2), .confirm(conf2), .inputData(dat2), .busy(bsy2),
    .fifo_count(cnt2)
`ifdef CTRL_REQUEST_SENDER_DROP_COUNT_EN
    , .drop_count(drop2)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (reset) begin
    if (req) reqQ.push_back(dat);
    if (conf) confQ.push_back(dat);
    if (req && conf) overlap++;
    if (req2) begin r2T.push_back(cyc); r2D.push_back(dat2); end
    if (conf2) c2T.push_back(cyc);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // call right after a rising edge; returns just after the edge that took the word
  task automatic push(logic t, logic [6:0] d);
    bit ok = 1'b0;
    pt = t; pd = d; pv = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!rdy && cnt == 3'd4) sawFull = 1'b1;
      if (rdy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clock); #1 pv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    pv = 0; pt = 0; pd = '0; pv2 = 0; pt2 = 0; pd2 = '0;
    for (int b = 0; b < 2; b++) begin
      logic t; logic [6:0] p; logic [7:0] d;
      t = (b == 0); p = (b == 0) ? 7'h2A : 7'h7F; d = (b == 0) ? 8'h55 : 8'hFE;
      tbl[b*8+0] = '{1'b1, t, p, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
      tbl[b*8+1] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1};
      tbl[b*8+2] = '{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, d, 1'b1, 1'b1, 3'd0};
      tbl[b*8+3] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, d, 1'b1, 1'b1, 3'd0};
      tbl[b*8+4] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, d, 1'b1, 1'b1, 3'd0};
      tbl[b*8+5] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b1, d, 1'b1, 1'b1, 3'd0};
      tbl[b*8+6] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
      tbl[b*8+7] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    end
    for (int i = 0; i < 6; i++) exp6[i] = {7'(i * 17 + 3), i[0]};
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_request", req, 0); chk("rst_confirm", conf, 0); chk("rst_data", dat, 0);
    chk("rst_busy", bsy, 0); chk("rst_ready", rdy, 1); chk("rst_count", cnt, 0);
`ifdef CTRL_REQUEST_SENDER_DROP_COUNT_EN
    chk("rst_drop", drop, 0);
`endif
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      pv = tbl[i].pv; pt = tbl[i].pt; pd = tbl[i].pd;
      @(negedge clock);
      chk($sformatf("v%0d_request", i), req, tbl[i].rq);
      chk($sformatf("v%0d_confirm", i), conf, tbl[i].cf);
      chk($sformatf("v%0d_data", i), dat, tbl[i].dat);
      chk($sformatf("v%0d_busy", i), bsy, tbl[i].bs);
      chk($sformatf("v%0d_ready", i), rdy, tbl[i].rdy);
      chk($sformatf("v%0d_count", i), cnt, tbl[i].cnt);
    end
    // fill and drain: six back-to-back pushes, the sixth must stall on a full FIFO
    reqQ.delete(); confQ.delete();
    @(posedge clock); #1;
    for (int i = 0; i < 6; i++) push(exp6[i][0], exp6[i][7:1]);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (cnt == 3'd0 && !bsy) break;
    end
    chk("fill_saw_full", sawFull, 1);
    chk("fill_idle", bsy, 0);
    chk("fill_req_count", reqQ.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fill_req%0d", i), reqQ.size() > i ? reqQ[i] : 8'hxx, exp6[i]);
      chk($sformatf("fill_conf%0d", i), confQ.size() > i ? confQ[i] : 8'hxx, exp6[i]);
    end
    // asynchronous reset during SETUP with a word still queued
    reqQ.delete(); confQ.delete();
    @(posedge clock); #1;
    push(1'b1, 7'h55);
    push(1'b0, 7'h11);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req) break;
    end
    chk("mid_saw_request", req, 1);
    @(posedge clock); #2;
    chk("mid_pre_count", cnt, 1);
    reset = 1'b0;
    #1;
    chk("mid_request", req, 0); chk("mid_confirm", conf, 0); chk("mid_data", dat, 0);
    chk("mid_busy", bsy, 0); chk("mid_count", cnt, 0); chk("mid_ready", rdy, 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (15) @(negedge clock);
    chk("mid_no_confirm", confQ.size(), 0);
    chk("mid_no_replay", reqQ.size(), 1);
    // SETUP_CYC=1, GAP_CYC=0 instance
    r2T.delete(); c2T.delete(); r2D.delete();
    @(posedge clock); #1 pv2 = 1'b1; pt2 = 1'b1; pd2 = 7'h0A;
    @(posedge clock); #1 pt2 = 1'b0; pd2 = 7'h0B;
    @(posedge clock); #1 pv2 = 1'b0;
    repeat (15) @(negedge clock);
    chk("sweep_req_count", r2T.size(), 2);
    chk("sweep_conf_gap", (c2T.size() > 0 && r2T.size() > 0) ? c2T[0] - r2T[0] : -1, 2);
    chk("sweep_req_gap", r2T.size() > 1 ? r2T[1] - r2T[0] : -1, 4);
    chk("sweep_data0", r2D.size() > 0 ? r2D[0] : 8'hxx, 8'h15);
    chk("sweep_data1", r2D.size() > 1 ? r2D[1] : 8'hxx, 8'h16);
`ifdef CTRL_REQUEST_SENDER_DROP_COUNT_EN
    @(posedge clock); #1 pv = 1'b1; pt = 1'b1; pd = 7'h33;
    repeat (400) @(posedge clock);
    @(negedge clock);
    chk("drop_saturate", drop, 8'hFF);
    @(posedge clock); #1 pv = 1'b0;
`endif
    chk("no_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
